// File: rtl/grf_wb_arbiter_if.sv
// GRF write-back bus shared by the requesters and the arbiter.
//   req_valid/req_ready : per-requester handshake (valid & ready = accept)
//   req_adr/data/pc     : per-requester payload, packed per requester index
//   wb_hold             : pipeline freeze, no grants while high
//   reg_write_enable, grf_adr_3, grf_write, PC : registered GRF write port
// slave modport = arbiter side, master modport = requester/GRF side.
interface grf_wb_arbiter_if #(parameter int N_REQ = 3);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0][4:0]  req_adr;
  logic [N_REQ-1:0][31:0] req_data;
  logic [N_REQ-1:0][31:0] req_pc;
  logic                   wb_hold;
  logic                   reg_write_enable;
  logic [4:0]             grf_adr_3;
  logic [31:0]            grf_write;
  logic [31:0]            PC;

  modport slave (
    input  req_valid, req_adr, req_data, req_pc, wb_hold,
    output req_ready, reg_write_enable, grf_adr_3, grf_write, PC
  );

  modport master (
    output req_valid, req_adr, req_data, req_pc, wb_hold,
    input  req_ready, reg_write_enable, grf_adr_3, grf_write, PC
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Round-robin arbiter sharing the single GRF write port among N_REQ
// write-back requesters, with one registered output stage and a saturating
// contention counter.
//   clk          : clock, all state on rising edge
//   reset        : asynchronous active-low reset
//   bus          : grf_wb_arbiter_if.slave (handshake, payload, GRF port)
//   conflict_cnt : cycles with >=2 valid requesters while not held (saturating)
module grf_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  grf_wb_arbiter_if.slave  bus,
  output logic [CNT_W-1:0] conflict_cnt
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IW = PW + 1;

  logic [PW-1:0]    ptr;
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gidx;
  logic             hit;
  logic [IW-1:0]    idx;
  logic [2:0]       nv;
  logic             multi;
  logic [IW-1:0]    nxt;

  // Search ptr, ptr+1, ... mod N_REQ; first valid wins. Ready is forced low
  // during reset so nothing is accepted while the output stage is cleared.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    hit  = 1'b0;
    idx  = '0;
    if (reset && !bus.wb_hold) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = {1'b0, ptr} + IW'(k);
        if (idx >= IW'(N_REQ)) idx = idx - IW'(N_REQ);
        if (!hit && bus.req_valid[idx[PW-1:0]]) begin
          hit                = 1'b1;
          gnt[idx[PW-1:0]]   = 1'b1;
          gidx               = idx[PW-1:0];
        end
      end
    end
  end

  assign bus.req_ready = gnt;

  always_comb begin
    nv = '0;
    for (int i = 0; i < N_REQ; i++) nv = nv + 3'(bus.req_valid[i]);
  end
  assign multi = (nv >= 3'd2);

  assign nxt = {1'b0, gidx} + IW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr                  <= '0;
      bus.reg_write_enable <= 1'b0;
      bus.grf_adr_3        <= '0;
      bus.grf_write        <= '0;
      bus.PC               <= '0;
      conflict_cnt         <= '0;
    end else begin
      bus.reg_write_enable <= hit;
      if (hit) begin
        // adr/data/PC only move on a grant; they hold between writes
        bus.grf_adr_3 <= bus.req_adr[gidx];
        bus.grf_write <= bus.req_data[gidx];
        bus.PC        <= bus.req_pc[gidx];
        ptr           <= (nxt == IW'(N_REQ)) ? '0 : nxt[PW-1:0];
      end
      if (multi && !bus.wb_hold && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: single write, round-robin order, hold,
// async reset mid-stream, $0 forwarding, and counter saturation on a second
// instance built with a 4-bit counter.
module tb_grf_wb_arbiter;
  logic clk;
  logic reset;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  int n_cmp;
  int n_bad;

  grf_wb_arbiter_if #(.N_REQ(3)) bus ();
  grf_wb_arbiter_if #(.N_REQ(3)) sbus ();

  assign sbus.req_valid = bus.req_valid;
  assign sbus.req_adr   = bus.req_adr;
  assign sbus.req_data  = bus.req_data;
  assign sbus.req_pc    = bus.req_pc;
  assign sbus.wb_hold   = bus.wb_hold;

  grf_wb_arbiter #(.N_REQ(3), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .conflict_cnt(cnt16));

  grf_wb_arbiter #(.N_REQ(3), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .bus(sbus), .conflict_cnt(cnt4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #1 reset = 1'b0;
    #1 reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_adr   = '0;
    bus.req_data  = '0;
    bus.req_pc    = '0;
    bus.wb_hold   = 1'b0;

    // reset state, ready forced low even with all valid
    #2;
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_en",    64'(bus.reg_write_enable), 64'h0);
    chk("rst_adr",   64'(bus.grf_adr_3), 64'h0);
    chk("rst_data",  64'(bus.grf_write), 64'h0);
    chk("rst_pc",    64'(bus.PC), 64'h0);
    chk("rst_cnt",   64'(cnt16), 64'h0);
    bus.req_valid = '0;
    tick();
    #2 reset = 1'b1;

    // 1: single write
    bus.req_valid   = 3'b001;
    bus.req_adr[0]  = 5'd5;
    bus.req_data[0] = 32'h0000_1234;
    bus.req_pc[0]   = 32'h0000_3000;
    #1 chk("t1_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    chk("t1_en",   64'(bus.reg_write_enable), 64'h1);
    chk("t1_adr",  64'(bus.grf_adr_3), 64'd5);
    chk("t1_data", 64'(bus.grf_write), 64'h1234);
    chk("t1_pc",   64'(bus.PC), 64'h3000);
    #1 chk("t1_ready0", 64'(bus.req_ready), 64'h0);
    tick();
    chk("t1_en0",   64'(bus.reg_write_enable), 64'h0);
    chk("t1_hold_adr", 64'(bus.grf_adr_3), 64'd5);
    chk("t1_cnt",   64'(cnt16), 64'h0);

    // 2: round-robin from a fresh pointer
    rst_pulse();
    for (int i = 0; i < 3; i++) begin
      bus.req_adr[i]  = 5'(10 + i);
      bus.req_data[i] = 32'hA0 + 32'(i);
      bus.req_pc[i]   = 32'h100 * 32'(i);
    end
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("t2_ready", 64'(bus.req_ready), 64'(3'b001 << (k % 3)));
      tick();
      chk("t2_en",   64'(bus.reg_write_enable), 64'h1);
      chk("t2_adr",  64'(bus.grf_adr_3), 64'(10 + (k % 3)));
      chk("t2_data", 64'(bus.grf_write), 64'(32'hA0 + 32'(k % 3)));
    end
    chk("t2_cnt", 64'(cnt16), 64'd6);

    // 3: hold; one more grant (req0) first so ptr=1 is saved across the hold
    #1 chk("t3_pre_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.wb_hold = 1'b1;
    #1 chk("t3_ready_h1", 64'(bus.req_ready), 64'h0);
    chk("t3_en_h1", 64'(bus.reg_write_enable), 64'h1);
    tick();
    chk("t3_en_h2", 64'(bus.reg_write_enable), 64'h0);
    chk("t3_ready_h2", 64'(bus.req_ready), 64'h0);
    tick();
    chk("t3_en_h3", 64'(bus.reg_write_enable), 64'h0);
    chk("t3_cnt_h3", 64'(cnt16), 64'd7);
    tick();
    bus.wb_hold = 1'b0;
    chk("t3_cnt_rel", 64'(cnt16), 64'd7);
    #1 chk("t3_ready_rel", 64'(bus.req_ready), 64'h2);
    tick();
    chk("t3_en_rel",  64'(bus.reg_write_enable), 64'h1);
    chk("t3_adr_rel", 64'(bus.grf_adr_3), 64'd11);
    chk("t3_cnt_after", 64'(cnt16), 64'd8);

    // 4: async reset in the middle of back-to-back writes
    #1 chk("t4_ready", 64'(bus.req_ready), 64'h4);
    #1 reset = 1'b0;
    #1;
    chk("t4_en",    64'(bus.reg_write_enable), 64'h0);
    chk("t4_adr",   64'(bus.grf_adr_3), 64'h0);
    chk("t4_data",  64'(bus.grf_write), 64'h0);
    chk("t4_pc",    64'(bus.PC), 64'h0);
    chk("t4_cnt",   64'(cnt16), 64'h0);
    chk("t4_ready_rst", 64'(bus.req_ready), 64'h0);
    bus.req_valid = 3'b110;
    #1 reset = 1'b1;
    #1 chk("t4_ready_rel", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    chk("t4_en1",   64'(bus.reg_write_enable), 64'h1);
    chk("t4_adr1",  64'(bus.grf_adr_3), 64'd11);
    chk("t4_data1", 64'(bus.grf_write), 64'hA1);
    chk("t4_pc1",   64'(bus.PC), 64'h100);
    tick();
    chk("t4_en0", 64'(bus.reg_write_enable), 64'h0);

    // 6: $0 write is forwarded unchanged
    bus.req_adr[2]  = 5'd0;
    bus.req_data[2] = 32'hDEAD_BEEF;
    bus.req_valid   = 3'b100;
    #1 chk("t6_ready", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = '0;
    chk("t6_en",   64'(bus.reg_write_enable), 64'h1);
    chk("t6_adr",  64'(bus.grf_adr_3), 64'h0);
    chk("t6_data", 64'(bus.grf_write), 64'hDEAD_BEEF);
    chk("t6_pc",   64'(bus.PC), 64'h200);
    tick();
    chk("t6_en0", 64'(bus.reg_write_enable), 64'h0);

    // 5: saturation of the 4-bit counter, 16-bit one keeps counting
    rst_pulse();
    bus.req_valid = 3'b011;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 14) chk("t5_sat14", 64'(cnt4), 64'hE);
      if (c == 15) chk("t5_sat15", 64'(cnt4), 64'hF);
      if (c == 20) begin
        chk("t5_sat20", 64'(cnt4), 64'hF);
        chk("t5_cnt20", 64'(cnt16), 64'd20);
      end
    end
    bus.req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
